sbox_share_arbiter: RTL

Time-shares one 32-bit SubWord unit (four S-box lookups) between the key-expansion engine and the cipher round datapath. Key expansion submits single 32-bit words. The round datapath submits full 128-bit states, which are substituted one word per cycle over four cycles. The block sits between those two requesters and replaces a full 16-S-box SubBytes instance, trading latency for area.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/sub_word.sv | 16 +
 rtl/sbox_share_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, arbiter encodings and the forward S-box table used by
// SubWord and SubBytes.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic {IDLE, S_BUSY} arb_state_t;
  typedef enum logic {KEY, STATE} grant_t;

  // One 128-bit row per high nibble; the leftmost byte is low nibble 0.
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = sbox(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one SubWord unit between single key-expansion words and 128-bit round
// states, the latter substituted one word per cycle over four cycles.
module sbox_share_arbiter
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       kreq_valid,
  input  aes_word_t  kreq_word,
  output logic       kreq_ready,
  output logic       kresp_valid,
  output aes_word_t  kresp_word,
  input  logic       sreq_valid,
  input  aes_state_t sreq_state,
  output logic       sreq_ready,
  output logic       sresp_valid,
  output aes_state_t sresp_state,
  output logic       busy
);

  arb_state_t state_q, state_d;
  logic [1:0] cnt_q;
  grant_t     last_grant_q;
  aes_state_t state_buf_q;
  aes_word_t  sw_in, sw_out;
  logic       kgrant, sgrant;

  sub_word u_sub_word (
    .word   (sw_in),
    .result (sw_out)
  );

  always_comb begin
    state_d = state_q;
    kgrant  = 1'b0;
    sgrant  = 1'b0;
    sw_in   = kreq_word;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not win last time is served.
        if (kreq_valid && (!sreq_valid || last_grant_q == STATE)) begin
          kgrant = 1'b1;
        end else if (sreq_valid) begin
          sgrant  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        sw_in = state_buf_q[{cnt_q, 5'b00000} +: 32];
        if (cnt_q == 2'd3) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kreq_ready = kgrant;
  assign sreq_ready = sgrant;
  assign busy       = (state_q == S_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= STATE;
      state_buf_q  <= '0;
      kresp_valid  <= 1'b0;
      kresp_word   <= '0;
      sresp_valid  <= 1'b0;
      sresp_state  <= '0;
    end else begin
      state_q     <= state_d;
      kresp_valid <= kgrant;
      sresp_valid <= 1'b0;
      if (kgrant) begin
        kresp_word   <= sw_out;
        last_grant_q <= KEY;
      end
      if (sgrant) begin
        state_buf_q  <= sreq_state;
        cnt_q        <= 2'd0;
        last_grant_q <= STATE;
      end
      if (state_q == S_BUSY) begin
        sresp_state[{cnt_q, 5'b00000} +: 32] <= sw_out;
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          sresp_valid <= 1'b1;
        end
      end
    end
  end

endmodule
